// File: rtl/fifo_mem_ctrl.sv
// Single-clock FIFO controller driving an external dual-port memory, with a
// first-word-fall-through valid/ready read side built from a 2-entry output skid.
module fifo_mem_ctrl #(
   parameter int DWIDTH     = 32,
   parameter int AWIDTH     = 3,
   parameter int AFULL_LVL  = 6,
   parameter int AEMPTY_LVL = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DWIDTH-1:0] wr_data,
   output logic              full,
   output logic              almost_full,
   output logic              overflow,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DWIDTH-1:0] rd_data,
   output logic              almost_empty,
   output logic [AWIDTH+1:0] level,
   output logic              mem_wen,
   output logic [AWIDTH:0]   mem_waddr,
   output logic [DWIDTH-1:0] mem_wdata,
   output logic              mem_ren,
   output logic              mem_roen,
   output logic [AWIDTH:0]   mem_raddr,
   input  logic [DWIDTH-1:0] mem_rdata
);

   localparam int PW = AWIDTH + 1;
   localparam int LW = AWIDTH + 2;

   logic [AWIDTH:0]   wptr, rptr, mem_count;
   logic              mem_empty;
   logic              inflight;
   logic [1:0]        ob_cnt, ob_after_pop;
   logic [2:0]        skid_demand;
   logic [DWIDTH-1:0] entry0, entry1;
   logic              pop;

   // Wrap-bit pointers: equal means empty, differing only in the MSB means full.
   assign mem_count = wptr - rptr;
   assign mem_empty = (wptr == rptr);
   assign full      = ((wptr ^ rptr) == {1'b1, {AWIDTH{1'b0}}});

   assign rd_valid = (ob_cnt != 2'd0);
   assign rd_data  = entry0;
   assign pop      = rd_valid && rd_ready;

   assign mem_wen   = wr_en && !full;
   assign mem_waddr = wptr;
   assign mem_wdata = wr_data;
   assign mem_roen  = 1'b1;
   assign mem_raddr = rptr;

   // Only issue a read when the skid is guaranteed a free slot for the returning word.
   assign skid_demand  = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
   assign mem_ren      = !mem_empty && (skid_demand < 3'd2);
   assign ob_after_pop = ob_cnt - {1'b0, pop};

   assign level        = {1'b0, mem_count} + LW'(inflight) + LW'(ob_cnt);
   assign almost_full  = (mem_count >= PW'(AFULL_LVL));
   assign almost_empty = (level <= LW'(AEMPTY_LVL));

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         inflight <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (mem_wen)
            wptr <= wptr + 1'b1;
         if (wr_en && full)
            overflow <= 1'b1;
         if (mem_ren)
            rptr <= rptr + 1'b1;
         inflight <= mem_ren;
      end
   end

   // NOTE: the skid entries are plain flops and are reset so rd_data reads 0 after rst;
   // the external memory array itself is never cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         ob_cnt <= 2'd0;
         entry0 <= '0;
         entry1 <= '0;
      end else begin
         ob_cnt <= ob_after_pop + {1'b0, inflight};
         if (pop)
            entry0 <= entry1;
         // A returning word lands in the first slot left free after this cycle's pop.
         if (inflight) begin
            if (ob_after_pop == 2'd0)
               entry0 <= mem_rdata;
            else
               entry1 <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Self-checking bench for fifo_mem_ctrl: behavioural dual-port memory, a data
// scoreboard queue and a pushes-minus-pops level model.
module tb_fifo_mem_ctrl;

   localparam int DWIDTH = 32;
   localparam int AWIDTH = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [DWIDTH-1:0] wr_data;
   logic              full, almost_full, overflow;
   logic              rd_valid, rd_ready;
   logic [DWIDTH-1:0] rd_data;
   logic              almost_empty;
   logic [AWIDTH+1:0] level;
   logic              mem_wen, mem_ren, mem_roen;
   logic [AWIDTH:0]   mem_waddr, mem_raddr;
   logic [DWIDTH-1:0] mem_wdata, mem_rdata;

   fifo_mem_ctrl #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .AFULL_LVL(6), .AEMPTY_LVL(1)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .almost_full(almost_full), .overflow(overflow),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .almost_empty(almost_empty), .level(level),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_ren(mem_ren), .mem_roen(mem_roen), .mem_raddr(mem_raddr),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural memory: synchronous read, data valid the cycle after mem_ren.
   logic [DWIDTH-1:0] mem [2**AWIDTH];
   always @(posedge clk) begin
      if (mem_wen)
         mem[mem_waddr[AWIDTH-1:0]] <= mem_wdata;
      if (mem_ren && mem_roen)
         mem_rdata <= mem[mem_raddr[AWIDTH-1:0]];
   end

   int n_checks = 0;
   int n_fail   = 0;
   logic [DWIDTH-1:0] sb [$];
   int model_lvl = 0;
   int n_pop     = 0;
   int wraps     = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      model_lvl = 0;
   endtask

   // One clock: drive inputs, check/score at negedge, advance past the edge.
   task automatic tick(input bit push, input logic [DWIDTH-1:0] d, input bit rdy, input bit exp_acc);
      bit popped;
      wr_en = push; wr_data = d; rd_ready = rdy;
      @(negedge clk);
      check("level", 64'(level), 64'(model_lvl));
      check("almost_empty", 64'(almost_empty), 64'(model_lvl <= 1));
      if (push) begin
         check("mem_wen", 64'(mem_wen), 64'(exp_acc));
         if (exp_acc) sb.push_back(d);
         if (mem_wen && mem_waddr == 4'hF) wraps++;
      end
      popped = rd_valid && rdy;
      if (popped) begin
         if (sb.size() == 0)
            check("pop_when_empty", 64'(rd_valid), 64'(0));
         else
            check("rd_data", 64'(rd_data), 64'(sb.pop_front()));
         n_pop++;
      end
      model_lvl += ((push && exp_acc) ? 1 : 0) - (popped ? 1 : 0);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (model_lvl == 0 && sb.size() == 0) break;
         tick(1'b0, '0, 1'b1, 1'b0);
      end
      check("drained_level", 64'(model_lvl), 64'(0));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int p0;
      bit burst;
      // 1. reset then idle
      do_reset();
      check("roen", 64'(mem_roen), 64'(1));
      check("rst_rd_data", 64'(rd_data), 64'(0));
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, '0, 1'b0, 1'b0);
         check("idle_rd_valid", 64'(rd_valid), 64'(0));
         check("idle_full", 64'(full), 64'(0));
         check("idle_afull", 64'(almost_full), 64'(0));
      end

      // 2. first-word latency
      tick(1'b1, 32'hA5A5_0001, 1'b0, 1'b1);
      check("lat_ren_c1", 64'(mem_ren), 64'(1));
      tick(1'b0, '0, 1'b0, 1'b0);
      check("lat_ren_c2", 64'(mem_ren), 64'(0));
      check("lat_valid_c2", 64'(rd_valid), 64'(0));
      tick(1'b0, '0, 1'b0, 1'b0);
      check("lat_valid_c3", 64'(rd_valid), 64'(1));
      check("lat_data_c3", 64'(rd_data), 64'hA5A5_0001);
      tick(1'b0, '0, 1'b0, 1'b0);
      check("lat_hold_data", 64'(rd_data), 64'hA5A5_0001);
      drain(10);

      // 3. fill past full with the consumer stalled
      for (int i = 0; i < 12; i++) begin
         if (i == 10) check("ovf_before", 64'(overflow), 64'(0));
         tick(1'b1, 32'(i), 1'b0, i < 10);
      end
      check("fill_level", 64'(level), 64'(10));
      check("fill_full", 64'(full), 64'(1));
      check("fill_afull", 64'(almost_full), 64'(1));
      check("fill_overflow", 64'(overflow), 64'(1));
      check("fill_valid", 64'(rd_valid), 64'(1));
      check("fill_head", 64'(rd_data), 64'(0));
      drain(40);
      check("ovf_sticky", 64'(overflow), 64'(1));

      // 4. streaming 0..99 with pointer wrap
      do_reset();
      check("ovf_cleared", 64'(overflow), 64'(0));
      wraps = 0;
      n_pop = 0;
      for (int i = 0; i < 110; i++) begin
         p0 = n_pop;
         tick(i < 100, 32'(i), 1'b1, 1'b1);
         if (p0 > 0 && p0 < 100) check("stream_gap", 64'(n_pop - p0), 64'(1));
      end
      check("stream_count", 64'(n_pop), 64'(100));
      check("stream_wraps", 64'(wraps), 64'(6));
      drain(10);

      // 5. reset mid-operation
      for (int i = 0; i < 5; i++) tick(1'b1, 32'(100 + i), 1'b0, 1'b1);
      tick(1'b0, '0, 1'b0, 1'b0);
      check("pre_rst_level", 64'(level), 64'(5));
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      model_lvl = 0;
      check("post_rst_level", 64'(level), 64'(0));
      check("post_rst_valid", 64'(rd_valid), 64'(0));
      check("post_rst_ovf", 64'(overflow), 64'(0));
      check("post_rst_full", 64'(full), 64'(0));
      check("post_rst_aempty", 64'(almost_empty), 64'(1));
      tick(1'b1, 32'h7, 1'b0, 1'b1);
      drain(10);
      check("post_rst_pops", 64'(sb.size()), 64'(0));

      // 6. random consumer against bursty producer
      burst = 1'b0;
      n_pop = 0;
      p0 = 0;
      for (int i = 0; i < 2000; i++) begin
         bit do_push;
         if ($urandom_range(0, 7) == 0) burst = !burst;
         do_push = burst && (model_lvl < 8);
         if (do_push) p0++;
         tick(do_push, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      end
      drain(40);
      check("rand_pops", 64'(n_pop), 64'(p0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
